// File: rtl/tlc_phase_sequencer.sv
// rtl/tlc_phase_sequencer.sv - highway/farm-road light phase sequencer driving the shared phase timer
module tlc_phase_sequencer #(
    parameter int           N    = 13,
    parameter logic [N-1:0] T_HG = 13'd4999,
    parameter logic [N-1:0] T_Y  = 13'd999,
    parameter logic [N-1:0] T_AR = 13'd199,
    parameter logic [N-1:0] T_FG = 13'd2999
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         farm_car,
    input  logic         ped_req,
    input  logic         tmr_done,
    output logic [N-1:0] tmr_final_value,
    output logic         tmr_restart_n,
    output logic [2:0]   hwy_light,
    output logic [2:0]   farm_light,
    output logic         walk
);
    localparam logic [2:0] S_HG  = 3'd0;
    localparam logic [2:0] S_HY  = 3'd1;
    localparam logic [2:0] S_AR1 = 3'd2;
    localparam logic [2:0] S_FG  = 3'd3;
    localparam logic [2:0] S_FY  = 3'd4;
    localparam logic [2:0] S_AR2 = 3'd5;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    logic [2:0]   state;
    logic [2:0]   state_nxt;
    logic         ped_pending;
    logic         min_green_met;
    logic         mgm_nxt;
    logic         done_q;
    logic         fg_entry;
    logic [N-1:0] final_nxt;
    logic [2:0]   hwy_nxt;
    logic [2:0]   farm_nxt;

    // The timer is held in restart while tmr_restart_n is low, so its done flag is stale then.
    assign done_q   = tmr_done & tmr_restart_n;
    assign fg_entry = (state_nxt == S_FG) && (state != S_FG);

    always_comb begin
        state_nxt = state;
        mgm_nxt   = min_green_met;
        case (state)
            S_AR2: if (done_q) state_nxt = S_HG;
            S_HG: begin
                mgm_nxt = min_green_met | done_q;
                if (mgm_nxt && (farm_car || ped_pending)) state_nxt = S_HY;
            end
            S_HY:  if (done_q) state_nxt = S_AR1;
            S_AR1: if (done_q) state_nxt = S_FG;
            S_FG:  if (done_q) state_nxt = S_FY;
            S_FY:  if (done_q) state_nxt = S_AR2;
            default: state_nxt = S_AR2;
        endcase
    end

    always_comb begin
        final_nxt = T_AR;
        hwy_nxt   = RED;
        farm_nxt  = RED;
        case (state_nxt)
            S_HG: begin final_nxt = T_HG; hwy_nxt = GRN; end
            S_HY: begin final_nxt = T_Y;  hwy_nxt = YEL; end
            S_FG: begin final_nxt = T_FG; farm_nxt = GRN; end
            S_FY: begin final_nxt = T_Y;  farm_nxt = YEL; end
            default: final_nxt = T_AR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_AR2;
            tmr_final_value <= T_AR;
            tmr_restart_n   <= 1'b0;
            hwy_light       <= RED;
            farm_light      <= RED;
            walk            <= 1'b0;
            ped_pending     <= 1'b0;
            min_green_met   <= 1'b0;
        end else begin
            state           <= state_nxt;
            tmr_final_value <= final_nxt;
            tmr_restart_n   <= (state_nxt == state);
            hwy_light       <= hwy_nxt;
            farm_light      <= farm_nxt;
            min_green_met   <= (state == S_HG && state_nxt == S_HG) ? mgm_nxt : 1'b0;
            // A press on the AR1->FG edge itself is still honoured in this farm phase.
            if (fg_entry) begin
                walk        <= ped_pending | ped_req;
                ped_pending <= 1'b0;
            end else begin
                if (state_nxt != S_FG) walk <= 1'b0;
                if (ped_req && state != S_FG) ped_pending <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_tlc_phase_sequencer.sv
// tb/tb_tlc_phase_sequencer.sv - self-checking bench for tlc_phase_sequencer with phase timer models
module tb_tlc_phase_sequencer;
    localparam logic [2:0]  R = 3'b100;
    localparam logic [2:0]  Y = 3'b010;
    localparam logic [2:0]  G = 3'b001;
    localparam logic [12:0] FA_HG = 13'd5;
    localparam logic [12:0] FA_Y  = 13'd2;
    localparam logic [12:0] FA_AR = 13'd1;
    localparam logic [12:0] FA_FG = 13'd4;
    localparam logic [12:0] FB_AR = 13'd0;

    typedef struct {
        logic        fc;
        logic        pr;
        logic [2:0]  h;
        logic [2:0]  f;
        logic        w;
        logic        rn;
        logic [12:0] fv;
    } vec_t;

    logic clk = 1'b0;
    logic reset_a = 1'b1, reset_b = 1'b1;
    logic fc_a = 1'b0, pr_a = 1'b0, fc_b = 1'b0, pr_b = 1'b0;
    logic [12:0] fv_a, fv_b;
    logic        rn_a, rn_b, walk_a, walk_b;
    logic [2:0]  hwy_a, farm_a, hwy_b, farm_b;
    logic [12:0] cnt_a = 13'd0, cnt_b = 13'd0;
    logic        done_a, done_b;

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t exp_q[$];
    vec_t table_a[$];

    always #5 clk = ~clk;

    tlc_phase_sequencer #(.N(13), .T_HG(FA_HG), .T_Y(FA_Y), .T_AR(FA_AR), .T_FG(FA_FG)) dut_a (
        .clk(clk), .reset(reset_a), .farm_car(fc_a), .ped_req(pr_a), .tmr_done(done_a),
        .tmr_final_value(fv_a), .tmr_restart_n(rn_a), .hwy_light(hwy_a), .farm_light(farm_a), .walk(walk_a)
    );

    tlc_phase_sequencer #(.N(13), .T_HG(FA_HG), .T_Y(FA_Y), .T_AR(FB_AR), .T_FG(FA_FG)) dut_b (
        .clk(clk), .reset(reset_b), .farm_car(fc_b), .ped_req(pr_b), .tmr_done(done_b),
        .tmr_final_value(fv_b), .tmr_restart_n(rn_b), .hwy_light(hwy_b), .farm_light(farm_b), .walk(walk_b)
    );

    // Phase timers: count 0..final, done while count == final, self-wrap, restart when rn low.
    assign done_a = (cnt_a == fv_a);
    assign done_b = (cnt_b == fv_b);
    always @(posedge clk) begin
        if (!rn_a) cnt_a <= 13'd0;
        else if (done_a) cnt_a <= 13'd0;
        else cnt_a <= cnt_a + 13'd1;
        if (!rn_b) cnt_b <= 13'd0;
        else if (done_b) cnt_b <= 13'd0;
        else cnt_b <= cnt_b + 13'd1;
    end

    function automatic vec_t mk(input logic fc, input logic pr, input logic [2:0] h, input logic [2:0] f,
                                input logic w, input logic rn, input logic [12:0] fv);
        vec_t v;
        v.fc = fc; v.pr = pr; v.h = h; v.f = f; v.w = w; v.rn = rn; v.fv = fv;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick(input bit b, input vec_t v);
        vec_t e;
        if (b) begin fc_b = v.fc; pr_b = v.pr; end
        else begin fc_a = v.fc; pr_a = v.pr; end
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check(b ? "hwy_b" : "hwy_a",   32'(b ? hwy_b  : hwy_a),  32'(e.h));
        check(b ? "farm_b" : "farm_a", 32'(b ? farm_b : farm_a), 32'(e.f));
        check(b ? "walk_b" : "walk_a", 32'(b ? walk_b : walk_a), 32'(e.w));
        check(b ? "restart_n_b" : "restart_n_a", 32'(b ? rn_b : rn_a), 32'(e.rn));
        check(b ? "final_b" : "final_a", 32'(b ? fv_b : fv_a), 32'(e.fv));
    endtask

    task automatic phase(input bit b, input int n, input logic [2:0] h, input logic [2:0] f, input logic w,
                         input logic [12:0] fv, input logic fc, input int pr_at, input bit entry);
        for (int i = 0; i < n; i++)
            tick(b, mk(fc, 1'(i == pr_at), h, f, w, !(entry && i == 0), fv));
    endtask

    task automatic add(input int n, input logic [2:0] h, input logic [2:0] f, input logic [12:0] fv, input int pr_at);
        for (int i = 0; i < n; i++)
            table_a.push_back(mk(1'b1, 1'(i == pr_at), h, f, 1'b0, 1'(i != 0), fv));
    endtask

    initial begin
        // farm_car held from the edge that leaves a 20-cycle HG: one full fixed-length cycle
        add(4, Y, R, FA_Y, -1);
        add(3, R, R, FA_AR, -1);
        add(6, R, G, FA_FG, 2);
        add(4, R, Y, FA_Y, -1);
        add(3, R, R, FA_AR, -1);
        add(7, G, R, FA_HG, -1);
        add(1, Y, R, FA_Y, -1);

        for (int i = 0; i < 3; i++) tick(0, mk(0, 0, R, R, 0, 0, FA_AR));
        reset_a = 1'b0;
        phase(0, 2, R, R, 0, FA_AR, 0, -1, 0);
        tick(0, mk(0, 0, G, R, 0, 0, FA_HG));
        check("mgm_a", 32'(dut_a.min_green_met), 32'd0);
        for (int i = 1; i <= 20; i++) begin
            tick(0, mk(0, 0, G, R, 0, 1, FA_HG));
            check("mgm_a", 32'(dut_a.min_green_met), 32'(i >= 7));
        end

        for (int i = 0; i < table_a.size(); i++) tick(0, table_a[i]);

        phase(0, 3, Y, R, 0, FA_Y, 0, -1, 0);
        phase(0, 3, R, R, 0, FA_AR, 0, -1, 1);
        phase(0, 6, R, G, 0, FA_FG, 0, -1, 1);
        phase(0, 4, R, Y, 0, FA_Y, 0, -1, 1);
        phase(0, 3, R, R, 0, FA_AR, 0, -1, 1);
        phase(0, 15, G, R, 0, FA_HG, 0, -1, 1);

        // single-cycle button press in HG with no car
        tick(0, mk(0, 1, G, R, 0, 1, FA_HG));
        phase(0, 4, Y, R, 0, FA_Y, 0, -1, 1);
        phase(0, 3, R, R, 0, FA_AR, 0, -1, 1);
        phase(0, 6, R, G, 1, FA_FG, 0, -1, 1);
        phase(0, 4, R, Y, 0, FA_Y, 0, -1, 1);
        phase(0, 3, R, R, 0, FA_AR, 0, -1, 1);
        phase(0, 12, G, R, 0, FA_HG, 0, -1, 1);

        // car and press on the same edge, then reset while walking
        tick(0, mk(1, 1, Y, R, 0, 0, FA_Y));
        phase(0, 3, Y, R, 0, FA_Y, 0, -1, 0);
        phase(0, 3, R, R, 0, FA_AR, 0, -1, 1);
        phase(0, 3, R, G, 1, FA_FG, 0, -1, 1);
        reset_a = 1'b1;
        tick(0, mk(0, 0, R, R, 0, 0, FA_AR));
        reset_a = 1'b0;
        phase(0, 2, R, R, 0, FA_AR, 0, -1, 0);
        phase(0, 10, G, R, 0, FA_HG, 0, -1, 1);

        // zero-length all-red: done is high during the restart cycle and must be ignored
        tick(1, mk(0, 0, R, R, 0, 0, FB_AR));
        check("done_b_in_restart", 32'(done_b), 32'd1);
        reset_b = 1'b0;
        tick(1, mk(1, 0, R, R, 0, 1, FB_AR));
        phase(1, 7, G, R, 0, FA_HG, 1, -1, 1);
        phase(1, 4, Y, R, 0, FA_Y, 1, -1, 1);
        phase(1, 2, R, R, 0, FB_AR, 1, -1, 1);
        phase(1, 6, R, G, 0, FA_FG, 1, -1, 1);
        phase(1, 4, R, Y, 0, FA_Y, 1, -1, 1);
        phase(1, 2, R, R, 0, FB_AR, 1, -1, 1);
        phase(1, 1, G, R, 0, FA_HG, 1, -1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
